// File: rtl/sdram_device_model.sv
// SDRAM device responder: decodes the controller's command bus, tracks the
// init sequence, per-bank open rows and the mode register, and serves
// read/write bursts from an internal word array with CAS-latency timing.
//
// state    | meaning
// PWRUP    | after reset, waiting for PRECHARGE ALL
// PRE_DONE | precharged, waiting for first AUTO REFRESH
// REF1     | one refresh seen, waiting for the second
// REF2     | two or more refreshes seen, waiting for LOAD MODE
// READY    | initialised, all commands accepted
module sdram_device_model #(
  parameter int MEM_ADDR_BITS = 12,
  parameter int COL_BITS      = 10
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        SDram_CKE_H,
  input  logic        SDram_CS_L,
  input  logic        SDram_RAS_L,
  input  logic        SDram_CAS_L,
  input  logic        SDram_WE_L,
  input  logic [12:0] SDram_Addr,
  input  logic [1:0]  SDram_BA,
  input  logic [15:0] SDram_DQ_In,
  output logic [15:0] SDram_DQ_Out,
  output logic        SDram_DQ_OE_H,
  output logic        InitDone_H,
  output logic [12:0] ModeReg,
  output logic        CmdError_H,
  output logic [15:0] RefreshCount
);

  typedef enum logic [2:0] {PWRUP, PRE_DONE, REF1, REF2, READY} init_e;
  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_LMR, CMD_BST
  } cmd_e;

  init_e               init_q, init_d;
  logic [12:0]         mode_q, mode_d;
  logic                err_q, err_d;
  logic [15:0]         ref_cnt_q, ref_cnt_d;
  logic [3:0]          bank_open_q, bank_open_d;
  logic [12:0]         bank_row_q [4];
  logic [12:0]         bank_row_d [4];
  logic                burst_q, burst_d;
  logic                burst_wr_q, burst_wr_d;
  logic [1:0]          burst_ba_q, burst_ba_d;
  logic [12:0]         burst_row_q, burst_row_d;
  logic [COL_BITS-1:0] burst_col_q, burst_col_d;
  logic [3:0]          burst_left_q, burst_left_d;
  logic [3:1]          pipe_vld_q, pipe_vld_d;
  logic [15:0]         pipe_dat_q [1:3];
  logic [15:0]         pipe_dat_d [1:3];
  logic [15:0]         dq_q, dq_d;
  logic                oe_q, oe_d;

  logic [15:0]              mem [2**MEM_ADDR_BITS];
  cmd_e                     cmd;
  logic                     mem_we;
  logic [MEM_ADDR_BITS-1:0] mem_idx;
  logic                     beat_go, beat_wr;
  logic [1:0]               beat_ba;
  logic [12:0]              beat_row;
  logic [COL_BITS-1:0]      beat_col;
  logic [3:0]               beat_left;
  logic [COL_BITS-1:0]      bl_mask;
  logic [3:0]               bl_beats;
  logic                     cl3;
  logic                     mode_bad;

  // Command decode from the strobe lines.
  always_comb begin
    cmd = CMD_NOP;
    if (!SDram_CS_L) begin
      case ({SDram_RAS_L, SDram_CAS_L, SDram_WE_L})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_LMR;
        3'b110:  cmd = CMD_BST;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  // Burst length mask and CAS latency from the mode register; unsupported
  // burst codes behave as BL=1, unsupported latencies as CL=2.
  always_comb begin
    bl_mask = '0;
    case (mode_q[2:0])
      3'd1:    bl_mask = COL_BITS'(1);
      3'd2:    bl_mask = COL_BITS'(3);
      3'd3:    bl_mask = COL_BITS'(7);
      default: bl_mask = '0;
    endcase
  end

  assign bl_beats = {1'b0, bl_mask[2:0]} + 4'd1;
  assign cl3      = (mode_q[6:4] == 3'd3);
  assign mode_bad = (SDram_Addr[2:0] > 3'd3) || SDram_Addr[3] ||
                    ((SDram_Addr[6:4] != 3'd2) && (SDram_Addr[6:4] != 3'd3));

  // Next-state: init FSM, bank table, burst engine and latency pipe.
  always_comb begin
    init_d       = init_q;
    mode_d       = mode_q;
    err_d        = err_q;
    ref_cnt_d    = ref_cnt_q;
    bank_open_d  = bank_open_q;
    bank_row_d   = bank_row_q;
    burst_d      = burst_q;
    burst_wr_d   = burst_wr_q;
    burst_ba_d   = burst_ba_q;
    burst_row_d  = burst_row_q;
    burst_col_d  = burst_col_q;
    burst_left_d = burst_left_q;
    pipe_vld_d   = pipe_vld_q;
    pipe_dat_d   = pipe_dat_q;
    dq_d         = dq_q;
    oe_d         = oe_q;
    mem_we       = 1'b0;
    beat_go      = 1'b0;
    beat_wr      = burst_wr_q;
    beat_ba      = burst_ba_q;
    beat_row     = burst_row_q;
    beat_col     = burst_col_q;
    beat_left    = burst_left_q;
    mem_idx      = '0;
    if (SDram_CKE_H) begin
      dq_d          = pipe_dat_q[1];
      oe_d          = pipe_vld_q[1];
      pipe_vld_d    = {1'b0, pipe_vld_q[3:2]};
      pipe_dat_d[1] = pipe_dat_q[2];
      pipe_dat_d[2] = pipe_dat_q[3];
      pipe_dat_d[3] = '0;
      beat_go       = burst_q;
      if (init_q != READY) begin
        case (init_q)
          PWRUP: begin
            if (cmd == CMD_PRE && SDram_Addr[10]) init_d = PRE_DONE;
            else if (cmd != CMD_NOP)              err_d  = 1'b1;
          end
          PRE_DONE, REF1: begin
            if (cmd == CMD_REF) begin
              init_d    = (init_q == PRE_DONE) ? REF1 : REF2;
              ref_cnt_d = ref_cnt_q + 16'd1;
            end else if (cmd != CMD_NOP) begin
              err_d = 1'b1;
            end
          end
          REF2: begin
            if (cmd == CMD_REF) begin
              if (ref_cnt_q != 16'hFFFF) ref_cnt_d = ref_cnt_q + 16'd1;
            end else if (cmd == CMD_LMR) begin
              mode_d = SDram_Addr;
              init_d = READY;
              if (mode_bad) err_d = 1'b1;
            end else if (cmd != CMD_NOP) begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (cmd)
          CMD_ACT: begin
            if (bank_open_q[SDram_BA]) err_d = 1'b1;
            else begin
              bank_open_d[SDram_BA] = 1'b1;
              bank_row_d[SDram_BA]  = SDram_Addr;
            end
          end
          CMD_RD, CMD_WR: begin
            if (!bank_open_q[SDram_BA]) err_d = 1'b1;
            else begin
              beat_go   = 1'b1;
              beat_wr   = (cmd == CMD_WR);
              beat_ba   = SDram_BA;
              beat_row  = bank_row_q[SDram_BA];
              beat_col  = SDram_Addr[COL_BITS-1:0];
              beat_left = (cmd == CMD_WR && mode_q[9]) ? 4'd1 : bl_beats;
              // A write takes the data bus back: pending read data is dropped.
              if (cmd == CMD_WR) begin
                pipe_vld_d = '0;
                pipe_dat_d = '{default: '0};
                dq_d       = '0;
                oe_d       = 1'b0;
              end
            end
          end
          CMD_PRE: begin
            if (SDram_Addr[10]) bank_open_d = '0;
            else                bank_open_d[SDram_BA] = 1'b0;
            if (SDram_Addr[10] || SDram_BA == burst_ba_q) beat_go = 1'b0;
          end
          CMD_REF: begin
            if (|bank_open_q)                err_d     = 1'b1;
            else if (ref_cnt_q != 16'hFFFF)  ref_cnt_d = ref_cnt_q + 16'd1;
          end
          CMD_LMR: begin
            mode_d = SDram_Addr;
            if (mode_bad || (|bank_open_q)) err_d = 1'b1;
          end
          CMD_BST: beat_go = 1'b0;
          default: ;
        endcase
      end
      mem_idx = MEM_ADDR_BITS'({beat_ba, beat_row, beat_col});
      if (beat_go) begin
        if (beat_wr) mem_we = 1'b1;
        else if (cl3) begin
          pipe_vld_d[3] = 1'b1;
          pipe_dat_d[3] = mem[mem_idx];
        end else begin
          pipe_vld_d[2] = 1'b1;
          pipe_dat_d[2] = mem[mem_idx];
        end
        burst_d      = (beat_left > 4'd1);
        burst_left_d = beat_left - 4'd1;
        burst_wr_d   = beat_wr;
        burst_ba_d   = beat_ba;
        burst_row_d  = beat_row;
        burst_col_d  = (beat_col & ~bl_mask) | ((beat_col + COL_BITS'(1)) & bl_mask);
      end else begin
        burst_d = 1'b0;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      init_q       <= PWRUP;
      mode_q       <= '0;
      err_q        <= 1'b0;
      ref_cnt_q    <= '0;
      bank_open_q  <= '0;
      bank_row_q   <= '{default: '0};
      burst_q      <= 1'b0;
      burst_wr_q   <= 1'b0;
      burst_ba_q   <= '0;
      burst_row_q  <= '0;
      burst_col_q  <= '0;
      burst_left_q <= '0;
      pipe_vld_q   <= '0;
      pipe_dat_q   <= '{default: '0};
      dq_q         <= '0;
      oe_q         <= 1'b0;
    end else begin
      init_q       <= init_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
      ref_cnt_q    <= ref_cnt_d;
      bank_open_q  <= bank_open_d;
      bank_row_q   <= bank_row_d;
      burst_q      <= burst_d;
      burst_wr_q   <= burst_wr_d;
      burst_ba_q   <= burst_ba_d;
      burst_row_q  <= burst_row_d;
      burst_col_q  <= burst_col_d;
      burst_left_q <= burst_left_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_dat_q   <= pipe_dat_d;
      dq_q         <= dq_d;
      oe_q         <= oe_d;
    end
  end

  // Backing array: deliberately not reset so contents survive a reset.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_idx] <= SDram_DQ_In;
  end

  assign SDram_DQ_Out  = dq_q;
  assign SDram_DQ_OE_H = oe_q;
  assign InitDone_H    = (init_q == READY);
  assign ModeReg       = mode_q;
  assign CmdError_H    = err_q;
  assign RefreshCount  = ref_cnt_q;

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed plus randomized bench for sdram_device_model; expected read data
// comes from a word-array model indexed by {BA,row,col} arithmetic.
module tb_sdram_device_model;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic        SDram_CKE_H;
  logic        SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L;
  logic [12:0] SDram_Addr;
  logic [1:0]  SDram_BA;
  logic [15:0] SDram_DQ_In;
  logic [15:0] SDram_DQ_Out;
  logic        SDram_DQ_OE_H;
  logic        InitDone_H;
  logic [12:0] ModeReg;
  logic        CmdError_H;
  logic [15:0] RefreshCount;

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                         C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                         C_LMR = 4'b0000, C_BST = 4'b0110;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] ref_mem [4096];

  always #5 Clock = ~Clock;

  sdram_device_model dut (
    .Clock(Clock), .Reset_L(Reset_L), .SDram_CKE_H(SDram_CKE_H),
    .SDram_CS_L(SDram_CS_L), .SDram_RAS_L(SDram_RAS_L),
    .SDram_CAS_L(SDram_CAS_L), .SDram_WE_L(SDram_WE_L),
    .SDram_Addr(SDram_Addr), .SDram_BA(SDram_BA), .SDram_DQ_In(SDram_DQ_In),
    .SDram_DQ_Out(SDram_DQ_Out), .SDram_DQ_OE_H(SDram_DQ_OE_H),
    .InitDone_H(InitDone_H), .ModeReg(ModeReg), .CmdError_H(CmdError_H),
    .RefreshCount(RefreshCount)
  );

  function automatic logic [11:0] midx(input int ba, input int row, input int col);
    return 12'((ba * (1 << 23) + row * (1 << 10) + col) % 4096);
  endfunction

  function automatic int bcol(input int start, input int k, input int bl);
    return (start / bl) * bl + ((start % bl) + k) % bl;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input int ba, input int a, input logic [15:0] d);
    {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L} = c;
    SDram_BA    = 2'(ba);
    SDram_Addr  = 13'(a);
    SDram_DQ_In = d;
    tick();
    {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L} = C_NOP;
  endtask

  task automatic init_seq(input int mode);
    drive(C_PRE, 0, 13'h400, 16'h0);
    drive(C_REF, 0, 0, 16'h0);
    drive(C_REF, 0, 0, 16'h0);
    drive(C_LMR, 0, mode, 16'h0);
  endtask

  task automatic open_bank(input int mode, input int ba, input int row);
    drive(C_PRE, 0, 13'h400, 16'h0);
    drive(C_LMR, 0, mode, 16'h0);
    drive(C_ACT, ba, row, 16'h0);
  endtask

  task automatic write_burst(input int ba, input int row, input int col, input int bl,
                             input bit single, input int base, input bit rnd);
    logic [15:0] d;
    for (int k = 0; k < bl; k++) begin
      d = rnd ? 16'($urandom) : 16'(base * (k + 1));
      if (k == 0) drive(C_WR, ba, col, d);
      else begin
        SDram_DQ_In = d;
        tick();
      end
      if (k == 0 || !single) ref_mem[midx(ba, row, bcol(col, k, bl))] = d;
    end
  endtask

  task automatic read_check(input string tag, input int ba, input int row, input int col,
                            input int bl, input int cl);
    drive(C_RD, ba, col, 16'h0);
    chk({tag, "_oe_cmd"}, 32'(SDram_DQ_OE_H), 32'd0);
    for (int i = 1; i <= cl + bl; i++) begin
      tick();
      if (i < cl) chk({tag, "_oe_early"}, 32'(SDram_DQ_OE_H), 32'd0);
      else if (i < cl + bl) begin
        chk({tag, "_oe"}, 32'(SDram_DQ_OE_H), 32'd1);
        chk({tag, "_dq"}, 32'(SDram_DQ_Out), 32'(ref_mem[midx(ba, row, bcol(col, i - cl, bl))]));
      end else chk({tag, "_oe_end"}, 32'(SDram_DQ_OE_H), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blc, bl, cl, ba, row, col;
    Reset_L     = 1'b0;
    SDram_CKE_H = 1'b1;
    {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L} = C_NOP;
    SDram_Addr  = '0;
    SDram_BA    = '0;
    SDram_DQ_In = '0;
    tick();
    tick();
    chk("rst_oe",   32'(SDram_DQ_OE_H), 32'd0);
    chk("rst_dq",   32'(SDram_DQ_Out),  32'd0);
    chk("rst_init", 32'(InitDone_H),    32'd0);
    chk("rst_mode", 32'(ModeReg),       32'd0);
    chk("rst_err",  32'(CmdError_H),    32'd0);
    chk("rst_ref",  32'(RefreshCount),  32'd0);
    Reset_L = 1'b1;
    tick();

    drive(C_PRE, 0, 13'h400, 16'h0);
    chk("pre_init", 32'(InitDone_H), 32'd0);
    drive(C_REF, 0, 0, 16'h0);
    drive(C_REF, 0, 0, 16'h0);
    chk("ref2_init", 32'(InitDone_H), 32'd0);
    drive(C_LMR, 0, 13'h022, 16'h0);
    chk("init_done", 32'(InitDone_H),   32'd1);
    chk("init_mode", 32'(ModeReg),      32'h022);
    chk("init_ref",  32'(RefreshCount), 32'd2);
    chk("init_err",  32'(CmdError_H),   32'd0);

    // Write then read back at CL=2, BL=4.
    drive(C_ACT, 1, 5, 16'h0);
    write_burst(1, 5, 0, 4, 1'b0, 16'h1111, 1'b0);
    read_check("wr_rd", 1, 5, 0, 4, 2);
    write_burst(1, 5, 4, 4, 1'b0, 0, 1'b1);
    write_burst(1, 5, 8, 4, 1'b0, 0, 1'b1);

    // Wrap within the aligned block at CL=3.
    open_bank(13'h032, 1, 5);
    chk("cl3_mode", 32'(ModeReg), 32'h032);
    read_check("wrap_cl3", 1, 5, 6, 4, 3);

    // Single-location writes, then a write that flushes a pending read.
    open_bank(13'h222, 1, 5);
    write_burst(1, 5, 9, 4, 1'b1, 0, 1'b1);
    read_check("single_wr", 1, 5, 8, 4, 2);
    drive(C_RD, 1, 8, 16'h0);
    drive(C_WR, 1, 12, 16'hBEEF);
    ref_mem[midx(1, 5, 12)] = 16'hBEEF;
    chk("flush_e1", 32'(SDram_DQ_OE_H), 32'd0);
    tick();
    chk("flush_e2", 32'(SDram_DQ_OE_H), 32'd0);
    tick();
    chk("flush_e3", 32'(SDram_DQ_OE_H), 32'd0);
    chk("pre_rand_err", 32'(CmdError_H), 32'd0);

    // Randomized burst writes and reads against the array model.
    for (int it = 0; it < 12; it++) begin
      blc = $urandom_range(0, 3);
      bl  = 1 << blc;
      cl  = $urandom_range(2, 3);
      ba  = $urandom_range(0, 3);
      row = $urandom_range(0, 8191);
      col = $urandom_range(0, 1023);
      open_bank((cl << 4) | blc, ba, row);
      write_burst(ba, row, col, bl, 1'b0, 0, 1'b1);
      read_check("rand", ba, row, (col / bl) * bl + int'($urandom_range(0, bl - 1)), bl, cl);
    end
    chk("rand_err", 32'(CmdError_H), 32'd0);

    // Burst terminate and clock suspend at BL=8, CL=2.
    open_bank(13'h023, 1, 5);
    write_burst(1, 5, 16, 8, 1'b0, 0, 1'b1);
    drive(C_RD, 1, 16, 16'h0);
    chk("bst_e0", 32'(SDram_DQ_OE_H), 32'd0);
    tick();
    chk("bst_e1", 32'(SDram_DQ_OE_H), 32'd0);
    drive(C_BST, 0, 0, 16'h0);
    chk("bst_b0_oe", 32'(SDram_DQ_OE_H), 32'd1);
    chk("bst_b0_dq", 32'(SDram_DQ_Out), 32'(ref_mem[midx(1, 5, 16)]));
    tick();
    chk("bst_b1_oe", 32'(SDram_DQ_OE_H), 32'd1);
    chk("bst_b1_dq", 32'(SDram_DQ_Out), 32'(ref_mem[midx(1, 5, 17)]));
    tick();
    chk("bst_stop0", 32'(SDram_DQ_OE_H), 32'd0);
    tick();
    chk("bst_stop1", 32'(SDram_DQ_OE_H), 32'd0);

    drive(C_RD, 1, 16, 16'h0);
    tick();
    tick();
    chk("cke_b0", 32'(SDram_DQ_Out), 32'(ref_mem[midx(1, 5, 16)]));
    SDram_CKE_H = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("cke_hold_oe", 32'(SDram_DQ_OE_H), 32'd1);
      chk("cke_hold_dq", 32'(SDram_DQ_Out), 32'(ref_mem[midx(1, 5, 16)]));
    end
    SDram_CKE_H = 1'b1;
    for (int j = 1; j < 8; j++) begin
      tick();
      chk("cke_res_oe", 32'(SDram_DQ_OE_H), 32'd1);
      chk("cke_res_dq", 32'(SDram_DQ_Out), 32'(ref_mem[midx(1, 5, 16 + j)]));
    end
    tick();
    chk("cke_end", 32'(SDram_DQ_OE_H), 32'd0);

    // Read to an idle bank.
    drive(C_PRE, 0, 13'h400, 16'h0);
    chk("idle_err_pre", 32'(CmdError_H), 32'd0);
    drive(C_RD, 2, 0, 16'h0);
    chk("idle_err", 32'(CmdError_H), 32'd1);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("idle_oe", 32'(SDram_DQ_OE_H), 32'd0);
    end

    // Reset in the middle of a read burst.
    drive(C_ACT, 1, 5, 16'h0);
    drive(C_RD, 1, 16, 16'h0);
    tick();
    tick();
    chk("mid_oe", 32'(SDram_DQ_OE_H), 32'd1);
    #2 Reset_L = 1'b0;
    #1;
    chk("mrst_oe",   32'(SDram_DQ_OE_H), 32'd0);
    chk("mrst_init", 32'(InitDone_H),    32'd0);
    chk("mrst_mode", 32'(ModeReg),       32'd0);
    chk("mrst_err",  32'(CmdError_H),    32'd0);
    chk("mrst_ref",  32'(RefreshCount),  32'd0);
    tick();
    Reset_L = 1'b1;
    tick();
    drive(C_ACT, 1, 5, 16'h0);
    chk("act_pre_init_err",  32'(CmdError_H), 32'd1);
    chk("act_pre_init_done", 32'(InitDone_H), 32'd0);
    Reset_L = 1'b0;
    tick();
    Reset_L = 1'b1;
    tick();
    init_seq(13'h022);
    chk("reinit_done", 32'(InitDone_H),   32'd1);
    chk("reinit_ref",  32'(RefreshCount), 32'd2);
    chk("reinit_err",  32'(CmdError_H),   32'd0);
    drive(C_ACT, 1, 5, 16'h0);
    read_check("keep", 1, 5, 0, 4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_device_model.md
Name: sdram_device_model

Overview:
- Synthesizable, cycle-accurate responder for the SDRAM command interface driven by the 68k DRAM controller; it plays the SDRAM chip on the far end of that interface.
- Decodes CS/RAS/CAS/WE commands, tracks the init sequence and per-bank open rows, and holds the mode register.
- Serves read/write bursts from a small internal word array.
- Used in simulation and in on-FPGA loopback tests of the controller; sticky flags report any protocol violation.

Parameters:
- MEM_ADDR_BITS, 12, log2 of backing-array depth in 16-bit words; the array index is the low MEM_ADDR_BITS bits of {BA[1:0], row[12:0], col[9:0]}.
- COL_BITS, 10, column bits taken from SDram_Addr[COL_BITS-1:0] on READ/WRITE.

Ports:
- Clock, in, 1, all state changes on the rising edge.
- Reset_L, in, 1, asynchronous active-low reset.
- SDram_CKE_H, in, 1, clock enable; low = clock suspend.
- SDram_CS_L, in, 1, chip select; high = NOP.
- SDram_RAS_L, in, 1, RAS.
- SDram_CAS_L, in, 1, CAS.
- SDram_WE_L, in, 1, write enable.
- SDram_Addr, in, 13, row, column, mode and A10 address.
- SDram_BA, in, 2, bank address.
- SDram_DQ_In, in, 16, write data from the controller.
- SDram_DQ_Out, out, 16, read data to the controller.
- SDram_DQ_OE_H, out, 1, high while SDram_DQ_Out carries valid read data.
- InitDone_H, out, 1, init sequence complete.
- ModeReg, out, 13, current mode register.
- CmdError_H, out, 1, sticky protocol-violation flag.
- RefreshCount, out, 16, number of AUTO REFRESH commands accepted; saturates at 16'hFFFF.

Behaviour:
- Reset (async, Reset_L=0):
  - All outputs are 0.
  - All banks are idle, the burst engine and latency pipe are cleared, and the init FSM is in PWRUP.
  - Array contents are not cleared.
- Command decode: {CS,RAS,CAS,WE} is sampled on the rising edge only when CKE=1.
  - CS=1 or 0111 = NOP.
  - 0011 = ACTIVE.
  - 0101 = READ.
  - 0100 = WRITE.
  - 0010 = PRECHARGE; A10=1 means all banks.
  - 0001 = AUTO REFRESH.
  - 0000 = LOAD MODE.
  - 0110 = BURST TERMINATE.
- CKE=0: the command is ignored, and the burst engine, latency pipe and DQ outputs hold their values.
- Init FSM:
  - PWRUP: PRECHARGE with A10=1 -> PRE_DONE.
  - PRE_DONE: first refresh -> REF1.
  - REF1: second refresh -> REF2.
  - REF2: further refreshes stay in REF2; LOAD MODE -> READY.
  - READY: InitDone_H=1.
  - Before READY, any ACTIVE, READ or WRITE, or any out-of-order init command, sets CmdError_H and is otherwise ignored.
  - NOPs are always legal.
- Mode register, latched on LOAD MODE:
  - Burst length from A2:0: 000=1, 001=2, 010=4, 011=8.
  - Burst type from A3: only sequential (0) is supported.
  - CAS latency from A6:4: only 2 and 3 are supported.
  - A9=1 selects single-location writes.
  - Unsupported values set CmdError_H; the value is still latched.
  - LOAD MODE with any bank active sets CmdError_H.
- Banks:
  - Each of the 4 banks is idle or active with a stored row.
  - ACTIVE to an idle bank opens the row given on SDram_Addr.
  - ACTIVE to an active bank, READ/WRITE to an idle bank, and REFRESH with any bank active each set CmdError_H; the command is then ignored.
  - PRECHARGE closes the bank selected by BA, or all banks when A10=1.
- Burst engine:
  - READ/WRITE starts a burst at the given column, issuing one beat per enabled edge: beat 0 on the command edge, BL beats in total.
  - Write beats are limited to 1 when A9=1.
  - Beat columns increment and wrap inside the BL-aligned block. Example: BL=4, start col 6 gives cols 6,7,4,5.
  - A write beat stores SDram_DQ_In into the array on that same edge.
  - A read beat reads the array; its data drives SDram_DQ_Out with SDram_DQ_OE_H=1 in the cycle starting exactly CL edges after the beat's edge.
  - The CL latency is implemented as a 3-deep valid/data pipe.
- Burst interruption:
  - A new READ or WRITE, a BURST TERMINATE, or a PRECHARGE of the bursting bank stops further beats from that edge.
  - A new READ/WRITE begins its own beat 0 on that same edge.
  - Read beats already issued still emerge; exception: a WRITE flushes the latency pipe, dropping pending read data and forcing OE low next cycle.
- Same-cycle read/write: a read beat and a write to the same address cannot occur on one edge, because only one burst is active at a time.
- CmdError_H stays high until reset.

Test Plan:
- Init: PRECHARGE with A10=1, 2x REFRESH, then LOAD MODE 13'h022 (BL=4, CL=2, sequential) -> InitDone_H=1, ModeReg=13'h022, RefreshCount=2, CmdError_H=0.
- Write then read (CL=2): ACTIVE BA=1 row=5; WRITE col 0 with data 1111,2222,3333,4444; READ col 0 -> OE high exactly 2 edges after READ for 4 cycles carrying 1111,2222,3333,4444.
- Wrap and CL=3: LOAD MODE 13'h032, then READ col 6 -> data from cols 6,7,4,5 starting 3 edges after the command.
- Errors: READ to idle bank 2 -> CmdError_H=1 and OE stays 0; ACTIVE before init in a fresh run -> CmdError_H=1.
- Interrupt and suspend: BURST TERMINATE 1 edge after a BL=8 READ -> exactly 2 beats output; CKE=0 for 3 cycles mid-burst -> DQ_Out holds and the burst resumes in order.
- Reset mid-burst: assert Reset_L=0 during a read burst -> OE=0, InitDone_H=0 and ModeReg=0 immediately; the array keeps its data after re-init.
